// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: memory-op encodings, MEM-stage FSM states and byte-lane helpers.
// Little-endian lanes: lane 0 is bits 7:0.
package cpu_defs_pkg;

   localparam logic [3:0] MEM_OP_NONE = 4'd0;
   localparam logic [3:0] MEM_OP_LB   = 4'd1;
   localparam logic [3:0] MEM_OP_LBU  = 4'd2;
   localparam logic [3:0] MEM_OP_LH   = 4'd3;
   localparam logic [3:0] MEM_OP_LHU  = 4'd4;
   localparam logic [3:0] MEM_OP_LW   = 4'd5;
   localparam logic [3:0] MEM_OP_SB   = 4'd6;
   localparam logic [3:0] MEM_OP_SH   = 4'd7;
   localparam logic [3:0] MEM_OP_SW   = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   localparam logic [3:0] LANE_BYTE0   = 4'b0001;
   localparam logic [3:0] LANE_HALF_LO = 4'b0011;
   localparam logic [3:0] LANE_HALF_HI = 4'b1100;
   localparam logic [3:0] LANE_WORD    = 4'b1111;

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
   endfunction

   function automatic logic is_load_op(input logic [3:0] op);
      return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
   endfunction

   function automatic logic is_store_op(input logic [3:0] op);
      return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
   endfunction

   function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] addr_lo);
      case (op)
         MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return LANE_BYTE0 << addr_lo;
         MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return addr_lo[1] ? LANE_HALF_HI : LANE_HALF_LO;
         MEM_OP_LW, MEM_OP_SW:             return LANE_WORD;
         default:                          return 4'b0000;
      endcase
   endfunction

   // Replicate narrow store data across every lane so the bus slave can use sel alone.
   function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] sdata);
      case (op)
         MEM_OP_SB: return {4{sdata[7:0]}};
         MEM_OP_SH: return {2{sdata[15:0]}};
         default:   return sdata;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
      case (op)
         MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return addr_lo[0];
         MEM_OP_LW, MEM_OP_SW:             return addr_lo != 2'b00;
         default:                          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the bus word
// and sign- or zero-extends it according to the load op.
module mem_load_align
   import cpu_defs_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [3:0]  op,
   output logic [31:0] value
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (op)
         MEM_OP_LB:  value = {{24{byte_v[7]}}, byte_v};
         MEM_OP_LBU: value = {24'b0, byte_v};
         MEM_OP_LH:  value = {{16{half_v[15]}}, half_v};
         MEM_OP_LHU: value = {16'b0, half_v};
         MEM_OP_LW:  value = rdata;
         default:    value = 32'b0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack bus and stalls the pipe meanwhile.
// Optional MEM_ALIGN_EXC_EN adds exc_align and suppresses misaligned accesses.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass through, memory ops stall and launch
// BUSY  | bus_req held with stable bus_*; waiting for bus_ack
// DONE  | read data captured; stall released for one cycle so MEM/WB takes the result
module mem_stage
   import cpu_defs_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] mem_wdata,
   input  logic [4:0]    mem_wd,
   input  logic          mem_wreg,
   input  logic [3:0]    mem_op,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_sdata,
   output logic [DW-1:0] wb_wdata,
   output logic [4:0]    wb_wd,
   output logic          wb_wreg,
   output logic          stallreq,
`ifdef MEM_ALIGN_EXC_EN
   output logic          exc_align,
`endif
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [3:0]    bus_sel,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   input  logic          bus_ack
);

   mem_state_e    state_q;
   mem_state_e    state_d;
   logic          is_mem;
   logic          misalign;
   logic          start;
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] load_val;

   assign is_mem = is_mem_op(mem_op);

`ifdef MEM_ALIGN_EXC_EN
   assign misalign = is_misaligned(mem_op, mem_addr[1:0]);
`else
   assign misalign = 1'b0;
`endif

   assign start = (state_q == ST_IDLE) && is_mem && !misalign;

   mem_load_align u_load_align (
      .rdata   (rdata_q),
      .addr_lo (mem_addr[1:0]),
      .op      (mem_op),
      .value   (load_val)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_BUSY;
         ST_BUSY: if (bus_ack) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      stallreq = 1'b0;
      wb_wdata = mem_wdata;
      wb_wd    = mem_wd;
      wb_wreg  = mem_wreg;
`ifdef MEM_ALIGN_EXC_EN
      exc_align = 1'b0;
`endif
      if (rst) begin
         wb_wdata = '0;
         wb_wd    = '0;
         wb_wreg  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               stallreq = start;
`ifdef MEM_ALIGN_EXC_EN
               if (misalign) begin
                  exc_align = 1'b1;
                  wb_wreg   = 1'b0;
               end
`endif
            end
            ST_BUSY: stallreq = 1'b1;
            ST_DONE: if (is_load_op(mem_op)) wb_wdata = load_val;
            default: ;
         endcase
      end
   end

   // Bus request side; everything is registered so the bus sees glitch-free signals.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_sel   <= 4'b0000;
         bus_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  bus_req   <= 1'b1;
                  bus_we    <= is_store_op(mem_op);
                  bus_addr  <= {mem_addr[AW-1:2], 2'b00};
                  bus_sel   <= lane_sel(mem_op, mem_addr[1:0]);
                  bus_wdata <= store_data(mem_op, mem_sdata);
               end
            end
            ST_BUSY: begin
               if (bus_ack) begin
                  rdata_q <= bus_rdata;
                  bus_req <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage CPU. Consumes the EX/MEM pipeline register outputs and drives the MEM/WB register inputs.
- Runs loads and stores over a req/ack data bus.
- Asserts a stall request to the pipeline controller while a bus access is outstanding.
- Non-memory instructions pass straight through with no stall.

Parameters:
- AW, 32, data bus address width.
- DW, 32, data width; fixed at 32. Byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_wdata  in  32  ALU result or pass-through write-back data
- mem_wd  in  5  destination register index
- mem_wreg  in  1  register write enable
- mem_op  in  4  memory op: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- mem_addr  in  AW  effective address
- mem_sdata  in  32  store data from rt
- wb_wdata  out  32  data to MEM/WB
- wb_wd  out  5  destination index to MEM/WB
- wb_wreg  out  1  write enable to MEM/WB
- stallreq  out  1  stall request to pipeline controller
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00}), registered
- bus_sel  out  4  byte-lane enables, registered
- bus_wdata  out  32  store data, registered
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  access complete; sampled only in BUSY

Behaviour:
- Little-endian lanes: addr[1:0]=0 selects bits 7:0.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - is_mem = mem_op in 1..8.
  - If is_mem: stallreq=1 combinationally. At the next edge, load bus_* and set bus_req=1. Go to BUSY.
  - Otherwise: stallreq=0 and outputs pass through (wb_wdata=mem_wdata).
- BUSY:
  - stallreq=1. All bus_* held stable.
  - On bus_ack: at the edge, rdata_q<=bus_rdata, bus_req<=0, go to DONE.
  - With no ack, wait indefinitely.
- DONE:
  - stallreq=0 for one cycle so MEM/WB captures the result and EX/MEM advances.
  - Next state is always IDLE. A memory op behind it starts in IDLE on the following cycle, so there is no re-issue.
- bus_sel and store data:
  - SB: sel = 4'b0001<<addr[1:0]; wdata = {4{sdata[7:0]}}.
  - SH: sel = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{sdata[15:0]}}.
  - SW: sel = 4'b1111; wdata = sdata.
  - Loads use the same sel pattern and bus_we=0.
- Load result (DONE, from rdata_q):
  - Byte = lane addr[1:0]. Halfword = addr[1] ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is the full word.
  - wb_wdata = extended value.
- Stores: wb_wdata = mem_wdata.
- wb_wd = mem_wd and wb_wreg = mem_wreg in all states. EX/MEM holds its inputs stable during a stall.
- Reset:
  - While rst=1, all combinational outputs are forced to 0.
  - At the edge, state<=IDLE and bus_req, bus_we, bus_addr, bus_sel, bus_wdata, rdata_q all <=0.
  - Reset mid-BUSY abandons the access; a late ack arriving in IDLE is ignored.
- Ack simultaneous with rst: rst wins.

Optional Feature:
- MEM_ALIGN_EXC_EN. When defined, adds output exc_align (1 bit, combinational).
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - On a misaligned op in IDLE: exc_align=1, stallreq=0, no bus access, wb_wreg=0. The FSM stays in IDLE.
- When undefined, there is no exc_align port:
  - Halfword ops ignore addr[0].
  - Word ops ignore addr[1:0].

Decomposition:
- Shared package cpu_defs_pkg holds:
  - MEM_OP_* encodings.
  - The state enum.
  - Lane constants.
- Natural sub-module: mem_load_align. Combinational; takes rdata, addr[1:0] and op, returns the extended load value.

Test Plan:
- ALU pass-through: op=NONE, wdata=0x1234, wd=5, wreg=1 -> same cycle wb_wdata=0x1234, wb_wreg=1, stallreq=0, bus_req never asserted.
- LB, addr=0x103, ack after 2 BUSY cycles, rdata=0x80AABBCC -> bus_addr=0x100, sel=1000; in DONE wb_wdata=0xFFFFFF80, stallreq high for 4 cycles (IDLE + 2 BUSY + ack cycle) then low for 1 cycle.
- LHU, addr=0x22, rdata=0x9ABC1234 -> sel=1100, wb_wdata=0x00009ABC.
- SB, addr=0x41, sdata=0x000000EE -> bus_we=1, sel=0010, bus_wdata=0xEEEEEEEE; SW, addr=0x40 -> sel=1111, wdata=sdata.
- Reset mid-BUSY (rst at 2nd BUSY cycle, ack one cycle later) -> bus_req=0, state IDLE, ack ignored, all outputs 0 during rst.
- MEM_ALIGN_EXC_EN: LW, addr=0x102 -> exc_align=1, bus_req stays 0, wb_wreg=0, stallreq=0.
